// File: rtl/tone_source_arbiter.sv
// tone_source_arbiter: fixed-priority owner arbitration (playback > live > demo) of the shared buzzer/display
// with a muted gap on owner change and ownership hold across key releases; ARB_DEMO_EN enables the demo requester.
module tone_source_arbiter #(
   parameter int GAP_CYCLES  = 50000,
   parameter int HOLD_CYCLES = 1000000
) (
   input  logic       clk_50mhz,
   input  logic       rst_n_internal,
   input  logic [2:0] live_key_id,
   input  logic       live_pressed,
   input  logic       live_oct_up,
   input  logic       live_oct_down,
   input  logic       pb_active,
   input  logic [2:0] pb_key_id,
   input  logic       pb_pressed,
   input  logic       pb_oct_up,
   input  logic       pb_oct_down,
   input  logic       demo_active,
   input  logic [2:0] demo_key_id,
   input  logic       demo_pressed,
   input  logic       demo_oct_up,
   input  logic       demo_oct_down,
   output logic [2:0] out_key_id,
   output logic       out_pressed,
   output logic       out_oct_up,
   output logic       out_oct_down,
   output logic [1:0] owner,
   output logic       switch_pulse,
   output logic       demo_preempted
);
`ifdef ARB_DEMO_EN
   localparam bit DEMO_EN = 1'b1;
`else
   localparam bit DEMO_EN = 1'b0;
`endif
   localparam int MAX_CYC = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
   localparam int CW = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GRANT, HOLD, GAP} state_t;

   state_t        state, state_nx;
   logic [1:0]    owner_nx, win;
   logic [CW-1:0] cnt, cnt_nx;
   logic          demo_req, own_req, higher;
   logic [2:0]    src_key, key_nx;
   logic          src_pressed, src_up, src_dn;
   logic          pressed_nx, up_nx, dn_nx, sw_nx, dp_nx;

   // Larger rank wins; owner 0 (none) ranks below every requester.
   function automatic logic [1:0] rank(input logic [1:0] o);
      return (o == 2'd2) ? 2'd3 : (o == 2'd1) ? 2'd2 : (o == 2'd3) ? 2'd1 : 2'd0;
   endfunction

   always_comb begin
      demo_req = DEMO_EN & demo_active;
      win      = pb_active ? 2'd2 : live_pressed ? 2'd1 : demo_req ? 2'd3 : 2'd0;
      own_req  = (owner == 2'd2) ? pb_active : (owner == 2'd1) ? live_pressed :
                 (owner == 2'd3) ? demo_req : 1'b0;
      higher   = rank(win) > rank(owner);
   end

   // During GAP the owner register carries the pending owner.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (win != 2'd0) begin
               state_nx = GRANT;
               owner_nx = win;
            end
         end
         GRANT: begin
            if (higher) begin
               state_nx = GAP;
               owner_nx = win;
               cnt_nx   = '0;
            end else if (!own_req) begin
               state_nx = HOLD;
               cnt_nx   = '0;
            end
         end
         HOLD: begin
            if (higher) begin
               state_nx = GAP;
               owner_nx = win;
               cnt_nx   = '0;
            end else if (own_req) begin
               state_nx = GRANT;
            end else if (cnt == HOLD_LAST) begin
               state_nx = (win != 2'd0) ? GAP : IDLE;
               owner_nx = win;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nx = '0;
               if (!own_req) begin
                  state_nx = (win != 2'd0) ? GRANT : IDLE;
                  owner_nx = win;
               end else begin
                  state_nx = GRANT;
               end
            end else begin
               cnt_nx   = cnt + 1'b1;
               owner_nx = higher ? win : owner;
            end
         end
      endcase
   end

   always_comb begin
      src_key     = (owner_nx == 2'd2) ? pb_key_id : (owner_nx == 2'd1) ? live_key_id :
                    (owner_nx == 2'd3) ? demo_key_id : 3'd0;
      src_pressed = (owner_nx == 2'd2) ? pb_pressed : (owner_nx == 2'd1) ? live_pressed :
                    (owner_nx == 2'd3) ? demo_pressed : 1'b0;
      src_up      = (owner_nx == 2'd2) ? pb_oct_up : (owner_nx == 2'd1) ? live_oct_up :
                    (owner_nx == 2'd3) ? demo_oct_up : 1'b0;
      src_dn      = (owner_nx == 2'd2) ? pb_oct_down : (owner_nx == 2'd1) ? live_oct_down :
                    (owner_nx == 2'd3) ? demo_oct_down : 1'b0;
      key_nx      = (state_nx == GRANT) ? src_key : (state_nx == HOLD) ? out_key_id : 3'd0;
      up_nx       = (state_nx == GRANT) ? src_up : (state_nx == HOLD) ? out_oct_up : 1'b0;
      dn_nx       = (state_nx == GRANT) ? src_dn : (state_nx == HOLD) ? out_oct_down : 1'b0;
      pressed_nx  = (state_nx == GRANT) & src_pressed;
      sw_nx       = (state_nx == GAP) & (state != GAP);
      dp_nx       = DEMO_EN & sw_nx & (owner == 2'd3);
   end

   always_ff @(posedge clk_50mhz or negedge rst_n_internal) begin
      if (!rst_n_internal) begin
         state          <= IDLE;
         owner          <= 2'd0;
         cnt            <= '0;
         out_key_id     <= 3'd0;
         out_pressed    <= 1'b0;
         out_oct_up     <= 1'b0;
         out_oct_down   <= 1'b0;
         switch_pulse   <= 1'b0;
         demo_preempted <= 1'b0;
      end else begin
         state          <= state_nx;
         owner          <= owner_nx;
         cnt            <= cnt_nx;
         out_key_id     <= key_nx;
         out_pressed    <= pressed_nx;
         out_oct_up     <= up_nx;
         out_oct_down   <= dn_nx;
         switch_pulse   <= sw_nx;
         demo_preempted <= dp_nx;
      end
   end
endmodule

// File: tb/tb_tone_source_arbiter.sv
// tb_tone_source_arbiter: directed and random stimulus, reference model feeds a scoreboard queue
// that a separate monitor drains every clock.
module tb_tone_source_arbiter;
   localparam int GAP  = 4;
   localparam int HOLD = 8;
`ifdef ARB_DEMO_EN
   localparam bit DEMO = 1'b1;
`else
   localparam bit DEMO = 1'b0;
`endif

   logic       clk_50mhz = 1'b0;
   logic       rst_n_internal = 1'b0;
   logic [2:0] live_key_id = 3'd0, pb_key_id = 3'd0, demo_key_id = 3'd0;
   logic       live_pressed = 1'b0, live_oct_up = 1'b0, live_oct_down = 1'b0;
   logic       pb_active = 1'b0, pb_pressed = 1'b0, pb_oct_up = 1'b0, pb_oct_down = 1'b0;
   logic       demo_active = 1'b0, demo_pressed = 1'b0, demo_oct_up = 1'b0, demo_oct_down = 1'b0;
   logic [2:0] out_key_id;
   logic       out_pressed, out_oct_up, out_oct_down, switch_pulse, demo_preempted;
   logic [1:0] owner;

   tone_source_arbiter #(.GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD)) dut (
      .clk_50mhz(clk_50mhz), .rst_n_internal(rst_n_internal),
      .live_key_id(live_key_id), .live_pressed(live_pressed),
      .live_oct_up(live_oct_up), .live_oct_down(live_oct_down),
      .pb_active(pb_active), .pb_key_id(pb_key_id), .pb_pressed(pb_pressed),
      .pb_oct_up(pb_oct_up), .pb_oct_down(pb_oct_down),
      .demo_active(demo_active), .demo_key_id(demo_key_id), .demo_pressed(demo_pressed),
      .demo_oct_up(demo_oct_up), .demo_oct_down(demo_oct_down),
      .out_key_id(out_key_id), .out_pressed(out_pressed),
      .out_oct_up(out_oct_up), .out_oct_down(out_oct_down),
      .owner(owner), .switch_pulse(switch_pulse), .demo_preempted(demo_preempted)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   typedef struct packed {
      logic [2:0] key;
      logic       pr;
      logic       up;
      logic       dn;
      logic [1:0] own;
      logic       sw;
      logic       dp;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // Model: current owner (0 = nobody), remaining gap cycles, remaining hold cycles, held display values.
   int         m_owner = 0, m_gap = 0, m_hold = 0;
   logic [2:0] m_key = 3'd0;
   logic       m_up = 1'b0, m_dn = 1'b0;

   function automatic int prio(input int o);
      return (o == 2) ? 3 : (o == 1) ? 2 : (o == 3) ? 1 : 0;
   endfunction

   function automatic int winner();
      if (pb_active) return 2;
      if (live_pressed) return 1;
      if (DEMO && demo_active) return 3;
      return 0;
   endfunction

   function automatic bit wants(input int o);
      if (o == 1) return live_pressed;
      if (o == 2) return pb_active;
      if (o == 3) return DEMO && demo_active;
      return 1'b0;
   endfunction

   task automatic model_step(output exp_t e);
      int prev, w;
      bit hi, rq, start;
      prev  = m_owner;
      w     = winner();
      hi    = prio(w) > prio(m_owner);
      rq    = wants(m_owner);
      start = 1'b0;
      e     = '0;
      if (m_gap > 0) begin
         if (m_gap == 1) begin
            m_gap = 0;
            if (!rq) m_owner = w;
         end else begin
            m_gap--;
            if (hi) m_owner = w;
         end
      end else if (m_owner == 0) begin
         m_owner = w;
      end else if (m_hold > 0) begin
         if (hi) start = 1'b1;
         else if (rq) m_hold = 0;
         else if (m_hold == 1) begin
            m_hold = 0;
            if (w != 0) start = 1'b1;
            else m_owner = 0;
         end else m_hold--;
      end else if (hi) begin
         start = 1'b1;
      end else if (!rq) begin
         m_hold = HOLD;
      end
      if (start) begin
         m_owner = w;
         m_gap   = GAP;
         m_hold  = 0;
      end
      e.own = 2'(m_owner);
      e.sw  = start;
      e.dp  = start && prev == 3;
      if (m_gap == 0 && m_owner != 0) begin
         if (m_hold > 0) begin
            e.key = m_key; e.up = m_up; e.dn = m_dn;
         end else if (m_owner == 1) begin
            e.key = live_key_id; e.pr = live_pressed; e.up = live_oct_up; e.dn = live_oct_down;
         end else if (m_owner == 2) begin
            e.key = pb_key_id; e.pr = pb_pressed; e.up = pb_oct_up; e.dn = pb_oct_down;
         end else begin
            e.key = demo_key_id; e.pr = demo_pressed; e.up = demo_oct_up; e.dn = demo_oct_down;
         end
      end
      m_key = e.key;
      m_up  = e.up;
      m_dn  = e.dn;
   endtask

   // Inputs are set just after a falling edge; the expectation covers the next rising edge.
   task automatic step(input int n = 1);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         model_step(e);
         q.push_back(e);
         @(negedge clk_50mhz);
      end
   endtask

   task automatic check_zero(input string name);
      n_chk++;
      if ({out_key_id, out_pressed, out_oct_up, out_oct_down, owner, switch_pulse, demo_preempted} != 10'd0) begin
         n_fail++;
         $display("FAIL %s: outputs key=%0d pr=%0b up=%0b dn=%0b own=%0d sw=%0b dp=%0b, required all 0",
                  name, out_key_id, out_pressed, out_oct_up, out_oct_down, owner, switch_pulse, demo_preempted);
      end
   endtask

   task automatic mid_reset();
      #2 rst_n_internal = 1'b0;
      #1 check_zero("async_reset");
      m_owner = 0; m_gap = 0; m_hold = 0; m_key = 3'd0; m_up = 1'b0; m_dn = 1'b0;
      repeat (2) @(negedge clk_50mhz);
      check_zero("reset_held");
      rst_n_internal = 1'b1;
   endtask

   task automatic rand_inputs(input int r);
      if ($urandom_range(r - 1) == 0) pb_active = ~pb_active;
      if ($urandom_range(r - 1) == 0) live_pressed = ~live_pressed;
      if ($urandom_range(r - 1) == 0) demo_active = ~demo_active;
      if ($urandom_range(2) == 0) {live_key_id, live_oct_up, live_oct_down} = 5'($urandom);
      if ($urandom_range(2) == 0) begin
         {pb_key_id, pb_oct_up, pb_oct_down} = 5'($urandom);
         pb_pressed = ($urandom_range(3) != 0);
      end
      if ($urandom_range(2) == 0) begin
         {demo_key_id, demo_oct_up, demo_oct_down} = 5'($urandom);
         demo_pressed = ($urandom_range(3) != 0);
      end
   endtask

   always @(posedge clk_50mhz) begin : monitor
      exp_t e, got;
      #1;
      if (q.size() > 0) begin
         e   = q.pop_front();
         got = {out_key_id, out_pressed, out_oct_up, out_oct_down, owner, switch_pulse, demo_preempted};
         n_chk++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL outputs @%0t: got key=%0d pr=%0b up=%0b dn=%0b own=%0d sw=%0b dp=%0b, required key=%0d pr=%0b up=%0b dn=%0b own=%0d sw=%0b dp=%0b",
                     $time, got.key, got.pr, got.up, got.dn, got.own, got.sw, got.dp,
                     e.key, e.pr, e.up, e.dn, e.own, e.sw, e.dp);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk_50mhz);
      check_zero("reset_state");
      rst_n_internal = 1'b1;
      step(3);
      live_key_id = 3'd3; live_pressed = 1'b1;
      step(3);
      live_pressed = 1'b0;
      step(5);
      live_key_id = 3'd5; live_pressed = 1'b1; live_oct_up = 1'b1; live_oct_down = 1'b1;
      step(3);
      live_key_id = 3'd2; live_oct_up = 1'b0; live_oct_down = 1'b0;
      step(2);
      pb_active = 1'b1; pb_key_id = 3'd6; pb_pressed = 1'b1;
      step(7);
      pb_pressed = 1'b0;
      step(2);
      pb_pressed = 1'b1;
      step(2);
      pb_active = 1'b0; live_pressed = 1'b0;
      step(14);
      demo_active = 1'b1; demo_key_id = 3'd4; demo_pressed = 1'b1;
      step(4);
      live_key_id = 3'd1; live_pressed = 1'b1;
      step(7);
      live_pressed = 1'b0;
      step(16);
      demo_active = 1'b0; live_pressed = 1'b1;
      step(4);
      pb_active = 1'b1;
      step(2);
      mid_reset();
      step(4);
      pb_active = 1'b0; live_pressed = 1'b0;
      step(12);
      for (int i = 0; i < 1500; i++) begin
         rand_inputs(6);
         step();
         if (i % 400 == 399) mid_reset();
      end
      for (int i = 0; i < 1500; i++) begin
         rand_inputs(14);
         step();
         if (i % 500 == 250) mid_reset();
      end
      @(posedge clk_50mhz);
      #2;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
